// File: rtl/clock_disp_pkg.sv
// Shared constants for the hh:mm:ss display stage: digit indices, glyphs, field limits.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied by the top.
package clock_disp_pkg;

  localparam logic [2:0] IDX_SEC_U = 3'd0;
  localparam logic [2:0] IDX_SEC_T = 3'd1;
  localparam logic [2:0] IDX_MIN_U = 3'd2;
  localparam logic [2:0] IDX_MIN_T = 3'd3;
  localparam logic [2:0] IDX_HR_U  = 3'd4;
  localparam logic [2:0] IDX_HR_T  = 3'd5;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam logic [6:0] MIN_MAX = 7'd59;
  localparam logic [6:0] HR_MAX  = 7'd23;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/clock_disp_mux_bin2bcd_2dig.sv
// Combinational 7-bit binary to two BCD digits (valid for 0..99) with an over-limit flag.
module bin2bcd_2dig (
  input  logic [6:0] i_bin,
  input  logic [6:0] i_limit,
  output logic [3:0] o_tens,
  output logic [3:0] o_units,
  output logic       o_oor
);

  assign o_tens  = 4'(i_bin / 7'd10);
  assign o_units = 4'(i_bin % 7'd10);
  assign o_oor   = (i_bin > i_limit);

endmodule

// File: rtl/clock_disp_mux.sv
// Six-digit multiplexed common-anode 7-seg driver for an hh:mm:ss counter, with blinking colon.
// Optional build macro CLOCK_DISP_HR12_EN selects 12-hour display with a PM indicator on digit 0.
module clock_disp_mux
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic [4:0] hr,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int               DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_idx;
  logic [6:0]       r_sec;
  logic [6:0]       r_min;
  logic [4:0]       r_hr;
  logic             r_load_pend;
  logic [5:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_done;

  logic             w_frame_end;
  logic             w_load;
  logic [3:0]       w_sec_t, w_sec_u, w_min_t, w_min_u, w_hr_t, w_hr_u;
  logic             w_sec_oor, w_min_oor, w_hr_oor;
  logic [6:0]       w_hr_val;
  logic             w_hr_bad;
  logic             w_hr_t_blank;
  logic             w_pm;
  logic [6:0]       w_glyph;
  logic             w_dp;

  assign w_frame_end = (r_idx == IDX_HR_T) && (r_div_cnt == DIV_LAST);
  assign w_load      = w_frame_end | r_load_pend;

  // Scan position and pending-snapshot flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt   <= '0;
      r_idx       <= IDX_SEC_U;
      r_load_pend <= 1'b1;
    end else if (!en) begin
      r_div_cnt   <= '0;
      r_idx       <= IDX_SEC_U;
      r_load_pend <= 1'b1;
    end else begin
      r_load_pend <= 1'b0;
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == IDX_HR_T) ? IDX_SEC_U : r_idx + 3'd1;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Shadow snapshot: only refreshed at frame boundaries so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec <= 7'd0;
      r_min <= 7'd0;
      r_hr  <= 5'd0;
    end else if (en && w_load) begin
      r_sec <= sec;
      r_min <= min;
      r_hr  <= hr;
    end
  end

`ifdef CLOCK_DISP_HR12_EN
  localparam logic [6:0] HR_LIM = 7'd12;

  // Map 0..23 onto 12-hour form; out-of-range hours are flagged separately
  always_comb begin
    if (r_hr == 5'd0) begin
      w_hr_val = 7'd12;
    end else if (r_hr > 5'd12) begin
      w_hr_val = {2'b00, r_hr} - 7'd12;
    end else begin
      w_hr_val = {2'b00, r_hr};
    end
  end

  assign w_hr_bad     = w_hr_oor | ({2'b00, r_hr} > HR_MAX);
  assign w_hr_t_blank = (w_hr_t == 4'd0);
  assign w_pm         = (r_hr >= 5'd12);
`else
  localparam logic [6:0] HR_LIM = HR_MAX;

  assign w_hr_val     = {2'b00, r_hr};
  assign w_hr_bad     = w_hr_oor;
  assign w_hr_t_blank = 1'b0;
  assign w_pm         = 1'b0;
`endif

  bin2bcd_2dig u_sec_bcd (.i_bin(r_sec),    .i_limit(SEC_MAX), .o_tens(w_sec_t), .o_units(w_sec_u), .o_oor(w_sec_oor));
  bin2bcd_2dig u_min_bcd (.i_bin(r_min),    .i_limit(MIN_MAX), .o_tens(w_min_t), .o_units(w_min_u), .o_oor(w_min_oor));
  bin2bcd_2dig u_hr_bcd  (.i_bin(w_hr_val), .i_limit(HR_LIM),  .o_tens(w_hr_t),  .o_units(w_hr_u),  .o_oor(w_hr_oor));

  // Glyph for the digit currently being scanned
  always_comb begin
    w_glyph = SEG_BLANK;
    case (r_idx)
      IDX_SEC_U: w_glyph = w_sec_oor ? SEG_DASH : seg_encode(w_sec_u);
      IDX_SEC_T: w_glyph = w_sec_oor ? SEG_DASH : seg_encode(w_sec_t);
      IDX_MIN_U: w_glyph = w_min_oor ? SEG_DASH : seg_encode(w_min_u);
      IDX_MIN_T: w_glyph = w_min_oor ? SEG_DASH : seg_encode(w_min_t);
      IDX_HR_U:  w_glyph = w_hr_bad  ? SEG_DASH : seg_encode(w_hr_u);
      IDX_HR_T: begin
        if (w_hr_bad) begin
          w_glyph = SEG_DASH;
        end else if (w_hr_t_blank) begin
          w_glyph = SEG_BLANK;
        end else begin
          w_glyph = seg_encode(w_hr_t);
        end
      end
      default:   w_glyph = SEG_BLANK;
    endcase
  end

  assign w_dp = (((r_idx == IDX_MIN_U) || (r_idx == IDX_HR_U)) && !r_sec[0])
              | ((r_idx == IDX_SEC_U) && w_pm);

  // Registered pin drivers, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an         <= 6'b111111;
      r_seg        <= {7{SEG_ACTIVE_LOW}};
      r_dp         <= SEG_ACTIVE_LOW;
      r_frame_done <= 1'b0;
    end else if (!en) begin
      r_an         <= 6'b111111;
      r_seg        <= {7{SEG_ACTIVE_LOW}};
      r_dp         <= SEG_ACTIVE_LOW;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= ~(6'b000001 << r_idx);
      r_seg        <= w_glyph ^ {7{SEG_ACTIVE_LOW}};
      r_dp         <= w_dp ^ SEG_ACTIVE_LOW;
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_clock_disp_mux.sv
// Randomized bench for clock_disp_mux against a position/arithmetic reference model.
// Honors CLOCK_DISP_HR12_EN the same way as the design.
module tb_clock_disp_mux;

  localparam int RD  = 4;
  localparam bit SAL = 1'b1;
  localparam int FRAME = 6 * RD;

  logic       clk;
  logic       rst;
  logic       en;
  logic [6:0] sec;
  logic [6:0] min;
  logic [4:0] hr;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

  int n_vec;
  int n_err;

  // Reference model state: position within the frame and the displayed snapshot
  int         m_pos;
  bit         m_pend;
  int         m_sec, m_min, m_hr;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  clock_disp_mux #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(SAL)) dut (
    .clk(clk), .rst(rst), .en(en), .sec(sec), .min(min), .hr(hr),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_glyph(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_glyph(input int idx);
    int  v, lim;
    bit  tens;
    tens = (idx % 2) == 1;
    case (idx / 2)
      0: begin v = m_sec; lim = 59; end
      1: begin v = m_min; lim = 59; end
      default: begin v = m_hr; lim = 23; end
    endcase
    if (v > lim) return 7'h40;
`ifdef CLOCK_DISP_HR12_EN
    if (idx / 2 == 2) begin
      if (v == 0) v = 12;
      else if (v > 12) v = v - 12;
      if (tens && v < 10) return 7'h00;
    end
`endif
    return digit_glyph(tens ? v / 10 : v % 10);
  endfunction

  function automatic bit exp_dp(input int idx);
    bit lit;
    lit = (idx == 2 || idx == 4) && (m_sec % 2 == 0);
`ifdef CLOCK_DISP_HR12_EN
    if (idx == 0 && m_hr >= 12) lit = 1'b1;
`endif
    return lit;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pend = 1'b1; m_sec = 0; m_min = 0; m_hr = 0;
    e_an = 6'h3F; e_seg = {7{SAL}}; e_dp = SAL; e_fd = 1'b0;
  endtask

  task automatic model_step();
    int idx;
    if (!en) begin
      e_an = 6'h3F; e_seg = {7{SAL}}; e_dp = SAL; e_fd = 1'b0;
      m_pos = 0; m_pend = 1'b1;
    end else begin
      idx   = (m_pos / RD) % 6;
      e_an  = 6'h3F & ~(6'd1 << idx);
      e_seg = exp_glyph(idx) ^ {7{SAL}};
      e_dp  = exp_dp(idx) ^ SAL;
      e_fd  = (m_pos % FRAME) == FRAME - 1;
      if (e_fd || m_pend) begin
        m_sec = int'(sec); m_min = int'(min); m_hr = int'(hr); m_pend = 1'b0;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic compare_outputs();
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run_until_idx(input int t);
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (((m_pos / RD) % 6) == t && (m_pos % RD) == 1) break;
      cycle();
    end
  endtask

  task automatic rand_fields();
    sec = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 59));
    min = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 59));
    hr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))  : 5'($urandom_range(0, 23));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; en = 1'b0; sec = 7'd0; min = 7'd0; hr = 5'd0;
    model_reset();
    repeat (2) cycle();

    rst = 1'b1; en = 1'b1; sec = 7'd7; min = 7'd45; hr = 5'd13;
    repeat (2 * FRAME) cycle();
    sec = 7'd8;
    repeat (FRAME + 6) cycle();

    run_until_idx(2);
    sec = 7'd7;
    repeat (2 * FRAME) cycle();

    sec = 7'd60; min = 7'd99; hr = 5'd24;
    repeat (2 * FRAME) cycle();
    sec = 7'd10; min = 7'd0; hr = 5'd0;
    repeat (2 * FRAME) cycle();
    hr = 5'd15; sec = 7'd33; min = 7'd9;
    repeat (2 * FRAME) cycle();
    hr = 5'd12;
    repeat (2 * FRAME) cycle();

    run_until_idx(3);
    rst = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    repeat (3) cycle();
    rst = 1'b1;
    repeat (2 * FRAME) cycle();

    run_until_idx(4);
    en = 1'b0;
    repeat (5) cycle();
    sec = 7'd21; min = 7'd2; hr = 5'd9;
    en = 1'b1;
    repeat (2 * FRAME) cycle();

    for (int n = 0; n < 2000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) rand_fields();
      if (en && r == 50) en = 1'b0;
      else if (!en && r < 20) en = 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        repeat (2) cycle();
        rst = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_disp_mux.md
Name: clock_disp_mux

Overview:
- Downstream display stage for the hh:mm:ss digital clock counter.
- Consumes binary sec/min/hr, snapshots them once per scan frame and converts each field to two BCD digits.
- Time-multiplexes six common-anode 7-segment digits (one-hot anode scan) with a blinking colon.
- Sits between the clock counter and the board's segment/anode pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is held lit; legal range is 2 or more.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light, 0 = high to light. Anodes are always active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  display enable
- sec  in  7  binary seconds, legal 0..59
- min  in  7  binary minutes, legal 0..59
- hr  in  5  binary hours, legal 0..23
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point of the active digit
- an  out  6  digit anodes, active-low; bit0 = rightmost digit
- frame_done  out  1  one-cycle pulse at the end of each 6-digit frame

Behaviour:
- Reset (rst=0, asynchronous):
  - div_cnt=0, idx=0, shadows=0, load_pend=1.
  - an=6'b111111, seg and dp unlit (polarity per SEG_ACTIVE_LOW), frame_done=0.
  - Takes effect immediately, including mid-frame.
- Scan counter:
  - div_cnt counts 0..REFRESH_DIV-1 while en=1.
  - At REFRESH_DIV-1: div_cnt returns to 0 and idx advances 0..5, wrapping 5->0.
- Frame end is the cycle where idx==5 and div_cnt==REFRESH_DIV-1.
  - frame_done=1 on the following cycle, for exactly one cycle.
- Snapshot:
  - sec/min/hr latch into shadow registers at frame end, or on any en=1 cycle where load_pend=1. The latter then clears load_pend.
  - Inputs changing mid-frame never alter the digits of the frame in progress (no tearing).
- Digit map:
  - idx0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens, 4 = hr units, 5 = hr tens.
- Conversion:
  - Tens = v/10, units = v%10, from the snapshot values.
  - Out-of-range snapshot (sec>59, min>59, hr>23): both digits of that field show dash (segment g only).
- 7-seg encoding: standard 0-9, no other glyphs except dash and blank.
- Colon:
  - dp lit on idx2 and idx4 when shadow sec is even; unlit when odd (1 Hz blink).
  - dp is unlit on all other digits.
- Output timing:
  - an, seg, dp are registered and reflect the idx/shadow state of the previous cycle (1-cycle latency).
  - an has exactly one bit low when enabled.
- en=0:
  - Synchronously force an=all ones, seg/dp unlit, div_cnt=0, idx=0, load_pend=1. No frame_done.
  - On re-enable, scan restarts at idx0 with a fresh snapshot on the first enabled cycle.

Optional Feature:
- Macro: CLOCK_DISP_HR12_EN.
- Defined: hours displayed in 12-hour form.
  - hr 0 -> 12; 1..12 unchanged; 13..23 -> hr-12.
  - Hour tens digit blanked when zero.
  - dp on idx0 lit when hr>=12 (PM indicator).
  - Out-of-range hr still shows dashes.
- Undefined: 24-hour display, leading zero shown, dp on idx0 never lit.

Decomposition:
- Shared package clock_disp_pkg:
  - digit index constants IDX_SEC_U..IDX_HR_T;
  - 7-bit glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-high form; polarity applied at output);
  - field limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
- One sub-module, bin2bcd_2dig:
  - combinational 7-bit binary to tens/units BCD for 0..99, plus an out-of-range flag at a limit input;
  - instantiated three times.

Test Plan:
- REFRESH_DIV=4, rst pulse low mid-frame at idx3 -> an=111111 immediately; after release and en=1, an walks 111110,111101,...,011111, each held 4 cycles. frame_done pulses once per 24 cycles.
- sec=7, min=45, hr=13, en=1 -> digits idx0..5 show 7,0,5,4,3,1. dp unlit on idx2/idx4 (sec odd). With sec=8, dp lit on idx2 and idx4.
- Change sec 7->8 at idx2 mid-frame -> idx0/1 of the current frame unchanged; next frame shows 8.
- sec=60, min=99, hr=24 -> idx0..5 all show SEG_DASH.
- en toggled 1->0->1 at idx4 -> an=111111 while low; resumes at idx0 with new snapshot, no spurious frame_done.
- CLOCK_DISP_HR12_EN defined:
  - hr=0 -> idx5/4 show 1,2 with PM dp off.
  - hr=15 -> idx5 blank, idx4 shows 3, dp on idx0 lit.
  - SEG_ACTIVE_LOW=0 -> seg polarity inverted vs default.
